// File: rtl/array_mul8_seq.sv
// array_mul8_seq: 8x8 unsigned multiply via four 4x4 partial products; ARRAY_MUL8_SEQ_MAC_EN adds acc_clr accumulate mode
module array_mul8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
`ifdef ARRAY_MUL8_SEQ_MAC_EN
    input  logic        acc_clr,
`endif
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;
    state_t      r_state;
    logic [7:0]  r_a, r_b;
    logic [15:0] r_acc;
    logic [3:0]  r_mul_a, r_mul_b;
    logic        r_in_ready, r_out_valid, r_busy;
    logic        w_clr;
    logic [15:0] w_add;
`ifdef ARRAY_MUL8_SEQ_MAC_EN
    assign w_clr = acc_clr;
`else
    assign w_clr = 1'b1;
`endif
    // cross terms (PP1, PP2) carry weight 2^4, the high-high term 2^8
    assign w_add = r_state == PP0 ? {8'd0, mul_p} :
                   r_state == PP3 ? {mul_p, 8'd0} : {4'd0, mul_p, 4'd0};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a        <= a;
                    r_b        <= b;
                    r_acc      <= w_clr ? 16'd0 : r_acc;
                    r_mul_a    <= a[3:0];
                    r_mul_b    <= b[3:0];
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                    r_state    <= PP0;
                end
                PP0: begin
                    r_acc   <= r_acc + w_add;
                    r_mul_a <= r_a[7:4];
                    r_mul_b <= r_b[3:0];
                    r_state <= PP1;
                end
                PP1: begin
                    r_acc   <= r_acc + w_add;
                    r_mul_a <= r_a[3:0];
                    r_mul_b <= r_b[7:4];
                    r_state <= PP2;
                end
                PP2: begin
                    r_acc   <= r_acc + w_add;
                    r_mul_a <= r_a[7:4];
                    r_mul_b <= r_b[7:4];
                    r_state <= PP3;
                end
                PP3: begin
                    r_acc       <= r_acc + w_add;
                    r_mul_a     <= '0;
                    r_mul_b     <= '0;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_acc;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
endmodule
